// File: rtl/rect_fill_writer_pkg.sv
// fb_pkg: shared constants and types for the rectangle fill writer.
//   - Framebuffer geometry (base address, logical width/height, row stride).
//   - RGB332 colour constants.
//   - Writer FSM state enum.
package fb_pkg;

    localparam logic [15:0] FB_BASE       = 16'h0000;
    localparam int          FB_W          = 160;
    localparam int          FB_H          = 120;
    localparam int          WORDS_PER_ROW = FB_W / 2;

    // RGB332 colours: rrr_ggg_bb
    localparam logic [7:0] BLACK   = 8'h00;
    localparam logic [7:0] BLUE    = 8'h03;
    localparam logic [7:0] GREEN   = 8'h1C;
    localparam logic [7:0] CYAN    = 8'h1F;
    localparam logic [7:0] RED     = 8'hE0;
    localparam logic [7:0] MAGENTA = 8'hE3;
    localparam logic [7:0] YELLOW  = 8'hFC;
    localparam logic [7:0] WHITE   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } fb_state_e;

endpackage

// File: rtl/rect_fill_writer_if.sv
// rect_fill_writer_if: video-memory write port.
//   mem_addr  : word address
//   mem_wdata : write data (two packed RGB332 pixels)
//   mem_be    : byte enables, [1]=even pixel (high byte), [0]=odd pixel (low byte)
//   mem_we    : write request (valid)
//   mem_ready : memory acceptance (ready)
// Handshake: a word transfers on a rising edge where mem_we && mem_ready.
// While mem_we is high and mem_ready is low, the master holds mem_addr,
// mem_be and mem_wdata stable; mem_we is never withdrawn before acceptance.
interface rect_fill_writer_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_we;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_be,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/rect_fill_writer_cursor.sv
// fb_cursor: row-major pixel cursor over the latched rectangle.
// Ports:
//   clk, clear     : clock, synchronous active-high reset
//   load           : latch rectangle, place cursor at (x0,y0)
//   x0,y0,x1,y1    : rectangle corners (inclusive), used when load=1
//   step           : current word accepted, advance cursor
//   addr           : word address of the current word
//   be             : byte enables of the current word
//   last           : current word is the final word of the rectangle
module fb_cursor
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    input  logic [7:0]  x1,
    input  logic [6:0]  y1,
    input  logic        step,
    output logic [15:0] addr,
    output logic [1:0]  be,
    output logic        last
);

    logic [8:0]  cx;
    logic [6:0]  cy;
    logic [15:0] row_base;
    logic [8:0]  x0_q;
    logic [8:0]  x1_q;
    logic [6:0]  y1_q;

    logic        even;
    logic        pair;
    logic [8:0]  end_cx;
    logic        row_end;
    logic [15:0] y0_ext;

    // The word covers two pixels only when cx is even and cx+1 is still inside.
    assign even    = ~cx[0];
    assign pair    = even && (cx < x1_q);
    assign end_cx  = pair ? (cx + 9'd1) : cx;
    assign row_end = (end_cx == x1_q);
    assign last    = row_end && (cy == y1_q);

    assign be   = pair ? 2'b11 : (even ? 2'b10 : 2'b01);
    assign addr = FB_BASE + row_base + {8'd0, cx[8:1]};

    // y0 * 80 as shifts; computed only once per rectangle.
    assign y0_ext = {9'd0, y0};

    always_ff @(posedge clk) begin
        if (clear) begin
            cx       <= '0;
            cy       <= '0;
            row_base <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
        end else if (load) begin
            cx       <= {1'b0, x0};
            cy       <= y0;
            row_base <= (y0_ext << 6) + (y0_ext << 4);
            x0_q     <= {1'b0, x0};
            x1_q     <= {1'b0, x1};
            y1_q     <= y1;
        end else if (step) begin
            if (row_end) begin
                cx       <= x0_q;
                cy       <= cy + 7'd1;
                row_base <= row_base + 16'(WORDS_PER_ROW);
            end else begin
                cx <= end_cx + 9'd1;
            end
        end
    end

endmodule

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: fills a rectangle of the 160x120 RGB332 framebuffer.
// Ports:
//   clk, clear          : clock, synchronous active-high reset
//   start               : fill request, sampled only in IDLE
//   x0,y0,x1,y1,color   : rectangle (inclusive corners) and fill colour
//   busy                : high while words are being written
//   done                : one-cycle pulse after the last write is accepted
//   err                 : one-cycle pulse after a rejected request
//   mem                 : video-memory write port (master side)
//   fsm_state           : current FSM state, for observation
module rect_fill_writer
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [7:0]           x0,
    input  logic [6:0]           y0,
    input  logic [7:0]           x1,
    input  logic [6:0]           y1,
    input  logic [7:0]           color,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    rect_fill_writer_if.master   mem,
    output fb_state_e            fsm_state
);

    fb_state_e   state_q, state_d;
    logic        err_q, err_d;
    logic [15:0] wdata_q;
    logic        load;
    logic        step;
    logic        req_ok;
    logic [15:0] cur_addr;
    logic [1:0]  cur_be;
    logic        cur_last;

    assign req_ok = (x0 <= x1) && (x1 < 8'(FB_W)) && (y0 <= y1) && (y1 < 7'(FB_H));
    assign step   = (state_q == WRITE) && mem.mem_ready;

    fb_cursor u_cursor (
        .clk   (clk),
        .clear (clear),
        .load  (load),
        .x0    (x0),
        .y0    (y0),
        .x1    (x1),
        .y1    (y1),
        .step  (step),
        .addr  (cur_addr),
        .be    (cur_be),
        .last  (cur_last)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (load) begin
                wdata_q <= {color, color};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        load    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (step && cur_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port outputs decode straight from state and cursor, so they stay
    // stable during stalls and drop to zero outside WRITE.
    always_comb begin
        mem.mem_we    = (state_q == WRITE);
        mem.mem_addr  = (state_q == WRITE) ? cur_addr : 16'd0;
        mem.mem_be    = (state_q == WRITE) ? cur_be : 2'b00;
        mem.mem_wdata = wdata_q;
    end

    assign busy      = (state_q == WRITE);
    assign done      = (state_q == FINISH);
    assign err       = err_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
module tb_rect_fill_writer;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [7:0]  x0, x1, color;
    logic [6:0]  y0, y1;
    logic        busy, done, err;
    fb_state_e   fsm_state;

    rect_fill_writer_if mem ();

    rect_fill_writer dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .color     (color),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem       (mem.master),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [33:0] exp_q[$];    // {addr, be, wdata}
    bit          mon_en   = 1'b0;
    logic [33:0] mon_got;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every accepted write is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && mem.mem_we && mem.mem_ready) begin
            mon_got = {mem.mem_addr, mem.mem_be, mem.mem_wdata};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=none", mon_got);
            end else begin
                check("write", mon_got, exp_q.pop_front());
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0]  x0;
        logic [6:0]  y0;
        logic [7:0]  x1;
        logic [6:0]  y1;
        logic [7:0]  color;
        int          n;
        logic [15:0] addr[4];
        logic [1:0]  be[4];
    } vec_t;

    vec_t vecs[6];

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [15:0] a, input logic [1:0] b, input logic [7:0] c);
        exp_q.push_back({a, b, c, c});
    endtask

    task automatic issue(input logic [7:0] ax0, input logic [6:0] ay0,
                         input logic [7:0] ax1, input logic [6:0] ay1, input logic [7:0] acol);
        @(posedge clk); #1;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = acol; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done with a cycle budget; with mem_ready held high the
    // done pulse must land exactly nwords+1 cycles after accept.
    task automatic wait_done(input int nwords, input int limit, input bit check_lat);
        int cyc = 1;
        bit seen = 1'b0;
        while (cyc <= limit && !seen) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else cyc++;
        end
        check("done_seen", 34'(seen), 34'd1);
        if (seen) begin
            if (check_lat) check("done_latency", 34'(cyc), 34'(nwords + 1));
            check("busy_at_done", 34'(busy), 34'd0);
            check("we_at_done", 34'(mem.mem_we), 34'd0);
            @(negedge clk);
            check("done_one_cycle", 34'(done), 34'd0);
            check("idle_after_done", 34'(fsm_state), 34'(IDLE));
        end
        check("queue_empty", 34'(exp_q.size()), 34'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        for (int k = 0; k < v.n; k++) push_exp(v.addr[k], v.be[k], v.color);
        issue(v.x0, v.y0, v.x1, v.y1, v.color);
        wait_done(v.n, 50, 1'b1);
    endtask

    task automatic run_invalid(input string name, input logic [7:0] ax0, input logic [6:0] ay0,
                               input logic [7:0] ax1, input logic [6:0] ay1);
        issue(ax0, ay0, ax1, ay1, WHITE);
        @(negedge clk);
        check({name, "_err"}, 34'(err), 34'd1);
        check({name, "_we"}, 34'(mem.mem_we), 34'd0);
        check({name, "_busy"}, 34'(busy), 34'd0);
        @(negedge clk);
        check({name, "_err_drop"}, 34'(err), 34'd0);
        check({name, "_we2"}, 34'(mem.mem_we), 34'd0);
        check({name, "_state"}, 34'(fsm_state), 34'(IDLE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clear = 1'b1; start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        mem.mem_ready = 1'b1;

        // single pixel at odd column: row 3 -> 240, column 5 -> word 2, low byte
        vecs[0] = '{x0:5,   y0:3,   x1:5,   y1:3,   color:RED,    n:1,
                    addr:'{242, 0, 0, 0},       be:'{2'b01, 2'b00, 2'b00, 2'b00}};
        vecs[1] = '{x0:2,   y0:0,   x1:5,   y1:0,   color:GREEN,  n:2,
                    addr:'{1, 2, 0, 0},         be:'{2'b11, 2'b11, 2'b00, 2'b00}};
        vecs[2] = '{x0:1,   y0:10,  x1:4,   y1:10,  color:BLUE,   n:3,
                    addr:'{800, 801, 802, 0},   be:'{2'b01, 2'b11, 2'b10, 2'b00}};
        vecs[3] = '{x0:6,   y0:119, x1:7,   y1:119, color:WHITE,  n:1,
                    addr:'{9523, 0, 0, 0},      be:'{2'b11, 2'b00, 2'b00, 2'b00}};
        vecs[4] = '{x0:3,   y0:1,   x1:3,   y1:2,   color:YELLOW, n:2,
                    addr:'{81, 161, 0, 0},      be:'{2'b01, 2'b01, 2'b00, 2'b00}};
        vecs[5] = '{x0:158, y0:5,   x1:159, y1:6,   color:MAGENTA, n:2,
                    addr:'{479, 559, 0, 0},     be:'{2'b11, 2'b11, 2'b00, 2'b00}};

        // reset state
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("rst_busy", 34'(busy), 34'd0);
        check("rst_done", 34'(done), 34'd0);
        check("rst_err", 34'(err), 34'd0);
        check("rst_we", 34'(mem.mem_we), 34'd0);
        check("rst_be", 34'(mem.mem_be), 34'd0);
        check("rst_addr", 34'(mem.mem_addr), 34'd0);
        check("rst_wdata", 34'(mem.mem_wdata), 34'd0);
        check("rst_state", 34'(fsm_state), 34'(IDLE));

        mon_en = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // backpressure on the second word of the odd-edge row
        push_exp(800, 2'b01, BLUE);
        push_exp(801, 2'b11, BLUE);
        push_exp(802, 2'b10, BLUE);
        issue(1, 10, 4, 10, BLUE);
        @(negedge clk);                 // first word presented, accepted next edge
        @(posedge clk); #1 mem.mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_addr", 34'(mem.mem_addr), 34'd801);
            check("stall_be", 34'(mem.mem_be), 34'b11);
            check("stall_wdata", 34'(mem.mem_wdata), 34'h0303);
            check("stall_we", 34'(mem.mem_we), 34'd1);
            if (s < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1 mem.mem_ready = 1'b1;
        @(negedge clk);
        check("resume_addr", 34'(mem.mem_addr), 34'd801);
        @(negedge clk);
        check("third_addr", 34'(mem.mem_addr), 34'd802);
        check("third_be", 34'(mem.mem_be), 34'b10);
        wait_done(0, 5, 1'b0);

        // rejected requests
        run_invalid("inv_x1", 8'd0, 7'd0, 8'd160, 7'd0);
        run_invalid("inv_y", 8'd0, 7'd20, 8'd10, 7'd19);
        run_invalid("inv_x", 8'd9, 7'd0, 8'd8, 7'd0);
        run_invalid("inv_y1", 8'd0, 7'd0, 8'd0, 7'd120);

        // clear in the middle of a full-screen fill
        mon_en = 1'b0;
        issue(0, 0, 159, 119, CYAN);
        repeat (10) @(negedge clk);
        check("fill_busy", 34'(busy), 34'd1);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        check("clr_we", 34'(mem.mem_we), 34'd0);
        check("clr_busy", 34'(busy), 34'd0);
        check("clr_done", 34'(done), 34'd0);
        check("clr_addr", 34'(mem.mem_addr), 34'd0);
        check("clr_state", 34'(fsm_state), 34'(IDLE));
        exp_q.delete();
        mon_en = 1'b1;
        run_vec(vecs[1]);

        // full screen
        for (int a = 0; a < 9600; a++) push_exp(16'(a), 2'b11, CYAN);
        issue(0, 0, 159, 119, CYAN);
        wait_done(9600, 9700, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
